lc3b_mem_ctrl: RTL and testbench

- Memory access sequencer directly downstream of the MAR register stage in the LC-3b datapath.
- Consumes MAR, the write data from MDR and the control signals MIO_EN, R_W and DATA_SIZE.
- Runs a req/ack transaction on the external memory bus, formats byte and word data in both directions, and returns the R (ready) pulse to the microsequencer.
- Detects unaligned word accesses and never issues them to the bus.

---
 rtl/lc3b_mem_ctrl.sv | 154 +++++++++++++++
 tb/tb_lc3b_mem_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/lc3b_mem_ctrl.sv
// LC-3b memory access sequencer: MAR/MDR to req/ack bus, byte-lane formatting, R pulse.
// Optional MEM_TIMEOUT_EN: abort a request that sees no mem_ack within TIMEOUT cycles.
module lc3b_mem_ctrl #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mio_en,
  input  logic              r_w,
  input  logic              data_size,
  input  logic [ADDR_W-1:0] mar,
  input  logic [DATA_W-1:0] wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic [1:0]        mem_be,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rdata,
  output logic              r,
  output logic              err_unaligned,
  output logic              err_timeout
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t            state_q;
  logic              size_q;
  logic              lsb_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              mem_we_q;
  logic [1:0]        mem_be_q;
  logic              mem_req_q;
  logic [DATA_W-1:0] rdata_q;
  logic              r_q;
  logic              err_unaligned_q;
  logic [DATA_W-1:0] rdata_d;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] tmo_cnt_q;
  logic             err_timeout_q;
  assign err_timeout = err_timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT != 0);
  assign err_timeout = 1'b0;
`endif

  // Read data formatting: byte reads are sign-extended from the addressed lane.
  always_comb begin
    rdata_d = mem_rdata;
    if (!size_q) begin
      if (lsb_q) rdata_d = {{(DATA_W-8){mem_rdata[15]}}, mem_rdata[15:8]};
      else       rdata_d = {{(DATA_W-8){mem_rdata[7]}},  mem_rdata[7:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      size_q          <= 1'b0;
      lsb_q           <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      mem_we_q        <= 1'b0;
      mem_be_q        <= 2'b00;
      mem_req_q       <= 1'b0;
      rdata_q         <= '0;
      r_q             <= 1'b0;
      err_unaligned_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      tmo_cnt_q       <= '0;
      err_timeout_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (mio_en) begin
            size_q <= data_size;
            lsb_q  <= mar[0];
            if (data_size && mar[0]) begin
              state_q         <= DONE;
              r_q             <= 1'b1;
              err_unaligned_q <= 1'b1;
            end else begin
              state_q    <= REQ;
              mem_req_q  <= 1'b1;
              mem_we_q   <= r_w;
              mem_addr_q <= {mar[ADDR_W-1:1], 1'b0};
              if (data_size) begin
                mem_be_q    <= 2'b11;
                mem_wdata_q <= wdata;
              end else begin
                mem_be_q    <= mar[0] ? 2'b10 : 2'b01;
                mem_wdata_q <= {wdata[7:0], wdata[7:0]};
              end
`ifdef MEM_TIMEOUT_EN
              tmo_cnt_q <= '0;
`endif
            end
          end
        end
        REQ: begin
          if (mem_ack) begin
            state_q   <= DONE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            mem_be_q  <= 2'b00;
            r_q       <= 1'b1;
            if (!mem_we_q) rdata_q <= rdata_d;
          end
`ifdef MEM_TIMEOUT_EN
          // The count reaches TIMEOUT on this cycle's increment; ack above takes priority.
          else if (tmo_cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_q       <= DONE;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_be_q      <= 2'b00;
            r_q           <= 1'b1;
            err_timeout_q <= 1'b1;
            rdata_q       <= '0;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
`endif
        end
        DONE: begin
          state_q         <= IDLE;
          r_q             <= 1'b0;
          err_unaligned_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
          err_timeout_q   <= 1'b0;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_we        = mem_we_q;
  assign mem_be        = mem_be_q;
  assign mem_req       = mem_req_q;
  assign rdata         = rdata_q;
  assign r             = r_q;
  assign err_unaligned = err_unaligned_q;

endmodule

// File: tb/tb_lc3b_mem_ctrl.sv
// Scoreboard bench for lc3b_mem_ctrl: directed accesses push expected bus/response items,
// a negedge monitor pops and compares them when mem_req rises and when r pulses.
module tb_lc3b_mem_ctrl;

`ifdef MEM_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mio_en = 1'b0, r_w = 1'b0, data_size = 1'b0;
  logic [15:0] mar = '0, wdata = '0;
  logic [15:0] mem_addr, mem_wdata, rdata;
  logic        mem_we, mem_req, r, err_unaligned, err_timeout;
  logic [1:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = 16'h5A5A;

  lc3b_mem_ctrl #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .mio_en(mio_en), .r_w(r_w), .data_size(data_size),
    .mar(mar), .wdata(wdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_be(mem_be), .mem_req(mem_req), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .rdata(rdata), .r(r), .err_unaligned(err_unaligned),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {logic [15:0] addr; logic [1:0] be; logic we; logic [15:0] wd;} bus_t;
  typedef struct {logic [15:0] rd; logic eu; logic et;} rsp_t;
  typedef struct {
    logic [15:0] mar, wd; logic rw, sz; int dly; logic [15:0] rd;
    logic bus; logic [15:0] e_addr; logic [1:0] e_be; logic [15:0] e_wd;
    logic [15:0] e_rd; logic e_u;
  } vec_t;

  bus_t bq[$];
  rsp_t sq[$];
  bus_t cur;
  int   n_cmp = 0, n_bad = 0;
  logic req_prev = 1'b0, r_prev = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (mem_req) begin
      if (!req_prev) begin
        if (bq.size() == 0) chk("unexpected_req", 1, 0);
        else cur = bq.pop_front();
      end
      chk("mem_addr", {16'h0, mem_addr}, {16'h0, cur.addr});
      chk("mem_be", {30'h0, mem_be}, {30'h0, cur.be});
      chk("mem_we", {31'h0, mem_we}, {31'h0, cur.we});
      chk("mem_wdata", {16'h0, mem_wdata}, {16'h0, cur.wd});
    end
    if (r) begin
      chk("r_width", {31'h0, r_prev}, 0);
      if (sq.size() == 0) chk("unexpected_r", 1, 0);
      else begin
        rsp_t e;
        e = sq.pop_front();
        chk("rdata", {16'h0, rdata}, {16'h0, e.rd});
        chk("err_unaligned", {31'h0, err_unaligned}, {31'h0, e.eu});
        chk("err_timeout", {31'h0, err_timeout}, {31'h0, e.et});
      end
    end else if (err_unaligned || err_timeout) begin
      chk("err_without_r", 1, 0);
    end
    req_prev = mem_req;
    r_prev   = r;
  end

  task automatic wait_drain(input string nm);
    int i;
    for (i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sq.size() == 0 && bq.size() == 0 && !r) break;
    end
    if (i == 40) begin
      chk({nm, "_resp_timeout"}, 1, 0);
      sq.delete();
      bq.delete();
    end
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    if (v.bus) bq.push_back('{v.e_addr, v.e_be, v.rw, v.e_wd});
    sq.push_back('{v.e_rd, v.e_u, 1'b0});
    mar = v.mar; wdata = v.wd; r_w = v.rw; data_size = v.sz; mio_en = 1'b1;
    @(negedge clk);
    mio_en = 1'b0;
    if (v.bus) begin
      mar = ~mar; wdata = ~wdata; r_w = ~r_w; data_size = ~data_size;
      repeat (v.dly) @(negedge clk);
      mem_ack = 1'b1; mem_rdata = v.rd;
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = 16'h5A5A;
    end
    wait_drain("vec");
  endtask

  vec_t vecs[10] = '{
    '{16'h3000, 16'h5555, 1'b0, 1'b1, 3, 16'hBEEF, 1'b1, 16'h3000, 2'b11, 16'h5555, 16'hBEEF, 1'b0},
    '{16'h3001, 16'h00C3, 1'b0, 1'b0, 1, 16'h80AA, 1'b1, 16'h3000, 2'b10, 16'hC3C3, 16'hFF80, 1'b0},
    '{16'h3000, 16'h0000, 1'b0, 1'b0, 0, 16'h80AA, 1'b1, 16'h3000, 2'b01, 16'h0000, 16'hFFAA, 1'b0},
    '{16'h4003, 16'h1234, 1'b1, 1'b0, 2, 16'hDEAD, 1'b1, 16'h4002, 2'b10, 16'h3434, 16'hFFAA, 1'b0},
    '{16'h5001, 16'h9999, 1'b0, 1'b1, 0, 16'h0000, 1'b0, 16'h0000, 2'b00, 16'h0000, 16'hFFAA, 1'b1},
    '{16'h6002, 16'hA5C3, 1'b1, 1'b1, 0, 16'h0000, 1'b1, 16'h6002, 2'b11, 16'hA5C3, 16'hFFAA, 1'b0},
    '{16'h7000, 16'h0000, 1'b0, 1'b0, 1, 16'h127F, 1'b1, 16'h7000, 2'b01, 16'h0000, 16'h007F, 1'b0},
    '{16'h7001, 16'h0000, 1'b0, 1'b0, 2, 16'h3C99, 1'b1, 16'h7000, 2'b10, 16'h0000, 16'h003C, 1'b0},
    '{16'h5003, 16'h4321, 1'b1, 1'b1, 0, 16'h0000, 1'b0, 16'h0000, 2'b00, 16'h0000, 16'h003C, 1'b1},
    '{16'h4000, 16'hABCD, 1'b1, 1'b0, 0, 16'h0000, 1'b1, 16'h4000, 2'b01, 16'hCDCD, 16'h003C, 1'b0}
  };

  initial begin
    int req_cycles;
    vec_t v;
    repeat (2) @(negedge clk);
    chk("rst_mem_req", {31'h0, mem_req}, 0);
    chk("rst_r", {31'h0, r}, 0);
    chk("rst_mem_be", {30'h0, mem_be}, 0);
    chk("rst_mem_addr", {16'h0, mem_addr}, 0);
    chk("rst_rdata", {16'h0, rdata}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i]);

    // mio_en held high: second unaligned access accepted in the IDLE cycle after DONE
    sq.push_back('{16'h003C, 1'b1, 1'b0});
    sq.push_back('{16'h003C, 1'b1, 1'b0});
    mar = 16'h5001; data_size = 1'b1; r_w = 1'b0; mio_en = 1'b1;
    repeat (3) @(negedge clk);
    mio_en = 1'b0;
    wait_drain("b2b");

    // Reset while mem_req is high
    bq.push_back('{16'h9000, 2'b11, 1'b0, 16'h0000});
    mar = 16'h9000; wdata = 16'h0000; data_size = 1'b1; r_w = 1'b0; mio_en = 1'b1;
    @(negedge clk);
    mio_en = 1'b0;
    chk("pre_rst_mem_req", {31'h0, mem_req}, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_mem_req", {31'h0, mem_req}, 0);
    chk("midrst_r", {31'h0, r}, 0);
    chk("midrst_rdata", {16'h0, rdata}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 16'h7777;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 16'h5A5A;
    repeat (3) @(negedge clk);
    chk("post_rst_req", {31'h0, mem_req}, 0);
    chk("post_rst_rdata", {16'h0, rdata}, 0);

    v = '{16'hA000, 16'h0000, 1'b0, 1'b1, 1, 16'h1111, 1'b1, 16'hA000, 2'b11, 16'h0000, 16'h1111, 1'b0};
    run_vec(v);

`ifdef MEM_TIMEOUT_EN
    bq.push_back('{16'hB000, 2'b11, 1'b0, 16'h0000});
    sq.push_back('{16'h0000, 1'b0, 1'b1});
    mar = 16'hB000; wdata = 16'h0000; data_size = 1'b1; r_w = 1'b0; mio_en = 1'b1;
    @(negedge clk);
    mio_en = 1'b0;
    req_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req) req_cycles++;
      else if (req_cycles > 0) break;
      @(negedge clk);
    end
    chk("timeout_req_cycles", req_cycles, 4);
    wait_drain("timeout");
`else
    req_cycles = 0;
`endif

    chk("bus_queue_empty", bq.size(), 0);
    chk("rsp_queue_empty", sq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
